// File: rtl/instruction_fetch_queue.sv
// Instruction fetch with synchronous on-chip memory and a decoupling queue.
// Fetched {pc, instr} pairs drain to decode via valid/ready; jumps flush all.
module instruction_fetch_queue #(
    parameter logic [31:0] PC_RESET_ADDR  = 32'h0000_0000,
    parameter int          IMEM_DEPTH     = 256,
    parameter int          FETCH_Q_DEPTH  = 4,
    parameter string       IMEM_INIT_FILE = ""
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             JumpFlag,
    input  logic [31:0]                      JumpAddr,
    input  logic                             imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0]    imem_waddr,
    input  logic [31:0]                      imem_wdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_pc,
    output logic [31:0]                      out_instr,
    output logic [31:0]                      pc,
    output logic [$clog2(FETCH_Q_DEPTH):0]   q_count
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int QA = $clog2(FETCH_Q_DEPTH);
    localparam int QW = QA + 1;

    logic [31:0]   mem [IMEM_DEPTH];
    logic [31:0]   rd_data;
    logic [31:0]   tag;
    logic          inflight;
    logic [31:0]   pc_r;
    logic [31:0]   q_pc    [FETCH_Q_DEPTH];
    logic [31:0]   q_instr [FETCH_Q_DEPTH];
    logic [QA-1:0] wr_ptr;
    logic [QA-1:0] rd_ptr;
    logic [QW-1:0] count;
    logic [AW-1:0] rd_idx;
    logic [QW:0]   credit;
    logic          pop;
    logic          push;
    logic          issue;
    logic          not_empty;

    assign rd_idx    = pc_r[AW+1:2];
    assign not_empty = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~JumpFlag & ~rst;

    // Credit counts entries already owed to the queue, so it never overflows
    assign credit = {1'b0, count}
                  - {{QW{1'b0}}, pop}
                  + {{QW{1'b0}}, inflight};
    assign issue  = ~rst & ~JumpFlag
                  & (credit < (QW+1)'(FETCH_Q_DEPTH));

    assign out_valid = not_empty & ~JumpFlag;
    assign out_pc    = not_empty ? q_pc[rd_ptr]    : 32'h0;
    assign out_instr = not_empty ? q_instr[rd_ptr] : 32'h0;
    assign pc        = pc_r;
    assign q_count   = count;

    // Memory write port; writes ignore reset so a loader can run anytime
    always_ff @(posedge clk) begin
        if (imem_we)
            mem[imem_waddr] <= imem_wdata;
    end

    // Synchronous read; a same-edge write to the word yields the old data
    always_ff @(posedge clk) begin
        if (issue) begin
            rd_data <= mem[rd_idx];
            tag     <= pc_r;
        end
    end

    // PC and in-flight tracking; reset beats redirect, redirect beats issue
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= PC_RESET_ADDR;
            inflight <= 1'b0;
        end else if (JumpFlag) begin
            pc_r     <= JumpAddr & 32'hFFFF_FFFC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue)
                pc_r <= pc_r + 32'd4;
        end
    end

    // Queue payload storage, written at the tail on a response
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= tag;
            q_instr[wr_ptr] <= rd_data;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk) begin
        if (rst || JumpFlag) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: vector table plus
// hand-written sequences for memory hazards and reset-address wrap.
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic [31:0] jaddr = 32'h0;
    logic        we = 1'b0;
    logic [7:0]  waddr = 8'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready = 1'b0;

    logic        valid, valid2;
    logic [31:0] opc, opc2, oinstr, oinstr2, fpc, fpc2;
    logic [2:0]  cnt, cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .PC_RESET_ADDR(32'h0), .IMEM_DEPTH(256),
        .FETCH_Q_DEPTH(4), .IMEM_INIT_FILE("")
    ) u_dut (
        .clk(clk), .rst(rst), .JumpFlag(jump), .JumpAddr(jaddr),
        .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata),
        .out_valid(valid), .out_ready(ready), .out_pc(opc),
        .out_instr(oinstr), .pc(fpc), .q_count(cnt)
    );

    instruction_fetch_queue #(
        .PC_RESET_ADDR(32'h3F8), .IMEM_DEPTH(256),
        .FETCH_Q_DEPTH(4), .IMEM_INIT_FILE("")
    ) u_dut2 (
        .clk(clk), .rst(rst), .JumpFlag(jump), .JumpAddr(jaddr),
        .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata),
        .out_valid(valid2), .out_ready(ready), .out_pc(opc2),
        .out_instr(oinstr2), .pc(fpc2), .q_count(cnt2)
    );

    typedef struct {
        logic        rst;
        logic        jump;
        logic [31:0] jaddr;
        logic        ready;
        logic        valid;
        logic [31:0] opc;
        logic [31:0] oinstr;
        logic [2:0]  cnt;
        logic [31:0] pc;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic j, input logic [31:0] ja,
                       input logic rd, input logic v, input logic [31:0] p,
                       input logic [31:0] ins, input logic [2:0] c,
                       input logic [31:0] f);
        vec_t e;
        e.rst = r; e.jump = j; e.jaddr = ja; e.ready = rd;
        e.valid = v; e.opc = p; e.oinstr = ins; e.cnt = c; e.pc = f;
        vt.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1 / 3: reset release, streaming, redirect to 0x43
        add(1,0,0,1,    0,32'h00,32'h0,0,32'h00);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h00);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h04);
        add(0,0,0,1,    1,32'h00,32'hA0000000,1,32'h08);
        add(0,0,0,1,    1,32'h04,32'hA0000001,1,32'h0C);
        add(0,0,0,1,    1,32'h08,32'hA0000002,1,32'h10);
        add(0,0,0,1,    1,32'h0C,32'hA0000003,1,32'h14);
        add(0,1,32'h43,1,0,32'h10,32'hA0000004,1,32'h18);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h40);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h44);
        add(0,0,0,1,    1,32'h40,32'hA0000010,1,32'h48);
        add(0,0,0,1,    1,32'h44,32'hA0000011,1,32'h4C);
        // Test 6: build 3 queued + 1 in flight, then reset
        add(0,0,0,0,    1,32'h48,32'hA0000012,1,32'h50);
        add(0,0,0,0,    1,32'h48,32'hA0000012,2,32'h54);
        add(1,0,0,0,    1,32'h48,32'hA0000012,3,32'h58);
        // Test 2: backpressure fills to 4 and freezes pc at 0x10
        add(0,0,0,0,    0,32'h00,32'h0,0,32'h00);
        add(0,0,0,0,    0,32'h00,32'h0,0,32'h04);
        add(0,0,0,0,    1,32'h00,32'hA0000000,1,32'h08);
        add(0,0,0,0,    1,32'h00,32'hA0000000,2,32'h0C);
        add(0,0,0,0,    1,32'h00,32'hA0000000,3,32'h10);
        add(0,0,0,0,    1,32'h00,32'hA0000000,4,32'h10);
        add(0,0,0,0,    1,32'h00,32'hA0000000,4,32'h10);
        add(0,0,0,1,    1,32'h00,32'hA0000000,4,32'h10);
        add(0,0,0,1,    1,32'h04,32'hA0000001,3,32'h14);
        add(0,0,0,1,    1,32'h08,32'hA0000002,3,32'h18);
        add(0,0,0,1,    1,32'h0C,32'hA0000003,3,32'h1C);
        // Test 4: full queue with decode stalled, then redirect
        add(0,0,0,0,    1,32'h10,32'hA0000004,3,32'h20);
        add(0,0,0,0,    1,32'h10,32'hA0000004,4,32'h20);
        add(0,1,32'h100,0,0,32'h10,32'hA0000004,4,32'h20);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h100);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h104);
        add(0,0,0,1,    1,32'h100,32'hA0000040,1,32'h108);
        // Back-to-back redirects: last wins, no issue while high
        add(0,1,32'h200,1,0,32'h104,32'hA0000041,1,32'h10C);
        add(0,1,32'h83,1,0,32'h00,32'h0,0,32'h200);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h80);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h84);
        add(0,0,0,1,    1,32'h80,32'hA0000020,1,32'h88);
        // Reset has priority over a simultaneous redirect
        add(1,1,32'h300,1,0,32'h84,32'hA0000021,1,32'h8C);
        add(0,0,0,1,    0,32'h00,32'h0,0,32'h00);

        // Load memory while reset is held
        #1;
        for (int k = 0; k < 256; k++) begin
            we = 1'b1;
            waddr = 8'(k);
            wdata = 32'hA000_0000 + 32'(k);
            step();
        end
        we = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst;
            jump = vt[i].jump;
            jaddr = vt[i].jaddr;
            ready = vt[i].ready;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vt[i].valid));
            chk($sformatf("v%0d_out_pc", i), opc, vt[i].opc);
            chk($sformatf("v%0d_out_instr", i), oinstr, vt[i].oinstr);
            chk($sformatf("v%0d_q_count", i), 32'(cnt), 32'(vt[i].cnt));
            chk($sformatf("v%0d_pc", i), fpc, vt[i].pc);
            step();
        end

        // Write and read of word 0 on the same edge returns old data
        jump = 1'b0; ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; we = 1'b1; waddr = 8'h0; wdata = 32'hDEAD_BEEF;
        step();
        we = 1'b0;
        step();
        chk("rdw_valid", 32'(valid), 32'h1);
        chk("rdw_old_pc", opc, 32'h0);
        chk("rdw_old_data", oinstr, 32'hA000_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        chk("rdw_new_data", oinstr, 32'hDEAD_BEEF);

        // Write during reset lands and is fetched after release
        rst = 1'b1; we = 1'b1; waddr = 8'h0; wdata = 32'hA000_0000;
        step();
        we = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        chk("rst_wr_pc", opc, 32'h0);
        chk("rst_wr_data", oinstr, 32'hA000_0000);

        // Test 5: reset address 0x3F8, index wraps past the depth
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("wrap_pc0", fpc2, 32'h3F8);
        chk("wrap_valid0", 32'(valid2), 32'h0);
        step();
        chk("wrap_pc1", fpc2, 32'h3FC);
        chk("wrap_valid1", 32'(valid2), 32'h0);
        step();
        chk("wrap_valid2", 32'(valid2), 32'h1);
        chk("wrap_opc2", opc2, 32'h3F8);
        chk("wrap_ins2", oinstr2, 32'hA000_00FE);
        step();
        chk("wrap_opc3", opc2, 32'h3FC);
        chk("wrap_ins3", oinstr2, 32'hA000_00FF);
        step();
        chk("wrap_opc4", opc2, 32'h400);
        chk("wrap_ins4", oinstr2, 32'hA000_0000);
        chk("wrap_cnt4", 32'(cnt2), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
